// File: rtl/udc_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : udc_host_sequencer
// Description : Bus master that loads one job (PLR, ULR, LLR, CCR) into an
//               up_down_counter255 over its ncs/nwr/nrd/a1/a0/din bus. It can
//               optionally read the four registers back to check them, then
//               pulses start, waits for ec/err or a timeout, and reports a
//               one-cycle done with status.
// Ports       : clk, reset (async, active-low)
//               cmd_valid/cmd_ready, cmd_plr/ulr/llr/ccr, cmd_verify : job port
//               ncs, nwr, nrd, a1, a0, din_out, din_oe, din_in     : counter bus
//               start, ec, err, dir                                : counter control
//               busy, done, status, last_dir                       : job result
// Revision    : 1.0 - initial release
// ============================================================================
module udc_host_sequencer #(
    parameter int TIMEOUT = 1023   // max WAIT cycles without ec/err; >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_plr,
    input  logic [7:0] cmd_ulr,
    input  logic [7:0] cmd_llr,
    input  logic [7:0] cmd_ccr,
    input  logic       cmd_verify,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a1,
    output logic       a0,
    output logic [7:0] din_out,
    output logic       din_oe,
    input  logic [7:0] din_in,
    output logic       start,
    input  logic       ec,
    input  logic       err,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic       last_dir
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TLAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    localparam logic [1:0] C_ST_OK  = 2'b00;
    localparam logic [1:0] C_ST_ERR = 2'b01;
    localparam logic [1:0] C_ST_TMO = 2'b10;
    localparam logic [1:0] C_ST_VFY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_STRT = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_job [4];   // indexed by register address
    logic          r_verify;
    logic [1:0]    r_idx;       // current write/read slot
    logic [1:0]    r_addr;
    logic          r_mis;       // sticky read-back mismatch
    logic [CW-1:0] r_tcnt;

    // Mismatch state including the read completing on this edge.
    logic w_rd_mis;
    assign w_rd_mis = r_mis | (din_in != r_job[r_idx]);

    assign a1 = r_addr[1];
    assign a0 = r_addr[0];

    // All bus/handshake outputs are registered: each transition programs the
    // output values of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < 4; i++) r_job[i] <= 8'd0;
            r_verify  <= 1'b0;
            r_idx     <= 2'd0;
            r_addr    <= 2'd0;
            r_mis     <= 1'b0;
            r_tcnt    <= '0;
            ncs       <= 1'b1;
            nwr       <= 1'b1;
            nrd       <= 1'b1;
            din_out   <= 8'd0;
            din_oe    <= 1'b0;
            start     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= C_ST_OK;
            last_dir  <= 1'b0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_job[0]  <= cmd_plr;
                        r_job[1]  <= cmd_ulr;
                        r_job[2]  <= cmd_llr;
                        r_job[3]  <= cmd_ccr;
                        r_verify  <= cmd_verify;
                        r_idx     <= 2'd0;
                        r_addr    <= 2'd0;
                        ncs       <= 1'b0;
                        nwr       <= 1'b0;
                        din_out   <= cmd_plr;
                        din_oe    <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_WR;
                    end
                end

                S_WR: begin
                    if (r_idx == 2'd3) begin
                        nwr     <= 1'b1;
                        din_oe  <= 1'b0;
                        din_out <= 8'd0;
                        r_idx   <= 2'd0;
                        r_addr  <= 2'd0;
                        if (r_verify) begin
                            nrd     <= 1'b0;
                            r_mis   <= 1'b0;
                            r_state <= S_RD;
                        end else begin
                            start   <= 1'b1;
                            r_state <= S_STRT;
                        end
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_addr  <= r_idx + 2'd1;
                        din_out <= r_job[r_idx + 2'd1];
                    end
                end

                S_RD: begin
                    if (r_idx == 2'd3) begin
                        nrd    <= 1'b1;
                        r_idx  <= 2'd0;
                        r_addr <= 2'd0;
                        if (w_rd_mis) begin
                            // Bad read-back: report without ever starting.
                            ncs     <= 1'b1;
                            done    <= 1'b1;
                            status  <= C_ST_VFY;
                            r_state <= S_DONE;
                        end else begin
                            start   <= 1'b1;
                            r_state <= S_STRT;
                        end
                    end else begin
                        r_mis  <= w_rd_mis;
                        r_idx  <= r_idx + 2'd1;
                        r_addr <= r_idx + 2'd1;
                    end
                end

                S_STRT: begin
                    // ec/err are deliberately not looked at here.
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (err || ec || (r_tcnt == C_TLAST)) begin
                        ncs      <= 1'b1;
                        done     <= 1'b1;
                        last_dir <= dir;
                        // err has priority over a simultaneous ec.
                        status   <= err ? C_ST_ERR : (ec ? C_ST_OK : C_ST_TMO);
                        r_state  <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + C_ONE;
                    end
                end

                S_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    ncs       <= 1'b1;
                    nwr       <= 1'b1;
                    nrd       <= 1'b1;
                    din_oe    <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
